// File: rtl/uart_transmit.sv
// UART transmitter: byte FIFO behind a valid/ready handshake feeding a
// start/data/parity/stop serialiser with a registered, idle-high txd line.
module uart_transmit #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     txd,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic          PAR_EN    = (PARITY_EN != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [7:0] value, input logic odd);
    return (^value) ^ odd;
  endfunction

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_s;
  logic          in_ready_r;
  logic          push_s;
  logic          pop_s;

  state_t        state_r;
  state_t        state_s;
  logic [15:0]   baud_r;
  logic [15:0]   baud_s;
  logic [2:0]    bit_r;
  logic [2:0]    bit_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_s;
  logic          parity_r;
  logic          parity_s;
  logic          baud_end_s;
  logic          txd_r;
  logic          txd_s;
  logic          busy_r;
  logic          busy_s;

  assign push_s     = in_valid && in_ready_r;
  assign pop_s      = (state_r == S_IDLE) && (count_r != CW'(0));
  assign baud_end_s = (baud_r == BAUD_LAST);

  assign in_ready   = in_ready_r;
  assign txd        = txd_r;
  assign busy       = busy_r;
  assign fifo_count = count_r;

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // Occupancy after this edge's push/pop pair
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO pointers, count and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= PW'(0);
      rd_ptr_r   <= PW'(0);
      count_r    <= CW'(0);
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r    <= count_s;
      in_ready_r <= (count_s != FULL);
    end
  end

  // Serialiser state register, including the registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      baud_r   <= 16'd0;
      bit_r    <= 3'd0;
      shift_r  <= 8'd0;
      parity_r <= 1'b0;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      baud_r   <= baud_s;
      bit_r    <= bit_s;
      shift_r  <= shift_s;
      parity_r <= parity_s;
      txd_r    <= txd_s;
      busy_r   <= busy_s;
    end
  end

  // Next-state logic; bit_r counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_s  = state_r;
    baud_s   = baud_r;
    bit_s    = bit_r;
    shift_s  = shift_r;
    parity_s = parity_r;
    case (state_r)
      S_IDLE: begin
        if (pop_s) begin
          state_s  = S_START;
          baud_s   = 16'd0;
          bit_s    = 3'd0;
          shift_s  = mem_r[rd_ptr_r];
          parity_s = parity_of(mem_r[rd_ptr_r], PAR_ODD);
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          state_s = S_DATA;
          baud_s  = 16'd0;
          bit_s   = 3'd0;
        end else begin
          baud_s  = baud_r + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_s  = 16'd0;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            bit_s   = 3'd0;
            state_s = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          baud_s  = baud_r + 16'd1;
        end
      end
      S_PARITY: begin
        if (baud_end_s) begin
          state_s = S_STOP;
          baud_s  = 16'd0;
          bit_s   = 3'd0;
        end else begin
          baud_s  = baud_r + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          baud_s = 16'd0;
          if (bit_r == STOP_LAST) begin
            state_s = S_IDLE;
            bit_s   = 3'd0;
          end else begin
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + 16'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
        baud_s  = 16'd0;
        bit_s   = 3'd0;
      end
    endcase
  end

  // Line level decoded from the upcoming state so txd changes on the same edge
  always_comb begin
    txd_s  = 1'b1;
    busy_s = (state_s != S_IDLE);
    case (state_s)
      S_START:  txd_s = 1'b0;
      S_DATA:   txd_s = shift_s[0];
      S_PARITY: txd_s = parity_r;
      S_STOP:   txd_s = 1'b1;
      S_IDLE:   txd_s = 1'b1;
      default:  txd_s = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit: four instances cover plain, even/odd
// parity and two-stop-bit framing; a bench-side receiver checks loopback.
module tb_uart_transmit;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data       [4];
  logic       in_valid   [4];
  logic       in_ready   [4];
  logic       txd        [4];
  logic       busy       [4];
  logic [2:0] fifo_count [4];

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] lb_bytes [4] = '{8'h00, 8'hFF, 8'h5A, 8'h80};

  always #5 clk = ~clk;

  uart_transmit #(.CLKS_PER_BIT(CPB), .DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .data(data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .txd(txd[0]), .busy(busy[0]), .fifo_count(fifo_count[0]));
  uart_transmit #(.CLKS_PER_BIT(CPB), .DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .data(data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .txd(txd[1]), .busy(busy[1]), .fifo_count(fifo_count[1]));
  uart_transmit #(.CLKS_PER_BIT(CPB), .DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .data(data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .txd(txd[2]), .busy(busy[2]), .fifo_count(fifo_count[2]));
  uart_transmit #(.CLKS_PER_BIT(CPB), .DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .data(data[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .txd(txd[3]), .busy(busy[3]), .fifo_count(fifo_count[3]));

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Called at the negedge showing the first start-bit cycle; returns at the
  // negedge of the cycle right after the last stop bit.
  task automatic check_frame(input int k, input logic [7:0] value, input bit par_en,
                             input bit par_bit, input int stops);
    logic [11:0] bits;
    int n;
    bits = 12'd0;
    n = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = value[i];
      n++;
    end
    if (par_en) begin
      bits[n] = par_bit;
      n++;
    end
    for (int s = 0; s < stops; s++) begin
      bits[n] = 1'b1;
      n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < CPB; c++) begin
        check_value($sformatf("u%0d_%02h_bit%0d_txd", k, value, b), 32'(txd[k]), 32'(bits[b]));
        check_value($sformatf("u%0d_%02h_bit%0d_busy", k, value, b), 32'(busy[k]), 32'd1);
        @(negedge clk);
      end
    end
  endtask

  task automatic idle_check(input int k);
    check_value($sformatf("u%0d_idle_txd", k), 32'(txd[k]), 32'd1);
    check_value($sformatf("u%0d_idle_busy", k), 32'(busy[k]), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data[k]     = 8'h00;
      in_valid[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_value($sformatf("u%0d_rst_txd", k), 32'(txd[k]), 32'd1);
      check_value($sformatf("u%0d_rst_busy", k), 32'(busy[k]), 32'd0);
      check_value($sformatf("u%0d_rst_ready", k), 32'(in_ready[k]), 32'd1);
      check_value($sformatf("u%0d_rst_count", k), 32'(fifo_count[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single byte, no parity: 40-cycle frame starting one edge after the push
    data[0] = 8'hA5;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    check_value("single_count_e", 32'(fifo_count[0]), 32'd1);
    check_value("single_txd_e", 32'(txd[0]), 32'd1);
    check_value("single_busy_e", 32'(busy[0]), 32'd0);
    @(negedge clk);
    check_value("single_count_e1", 32'(fifo_count[0]), 32'd0);
    check_frame(0, 8'hA5, 1'b0, 1'b0, 1);
    idle_check(0);

    // Even parity: A5 -> 0, 07 -> 1, queued back to back
    data[1] = 8'hA5;
    in_valid[1] = 1'b1;
    @(negedge clk);
    data[1] = 8'h07;
    @(negedge clk);
    in_valid[1] = 1'b0;
    check_frame(1, 8'hA5, 1'b1, 1'b0, 1);
    idle_check(1);
    check_frame(1, 8'h07, 1'b1, 1'b1, 1);
    idle_check(1);

    // Odd parity: A5 -> 1
    data[2] = 8'hA5;
    in_valid[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    @(negedge clk);
    check_frame(2, 8'hA5, 1'b1, 1'b1, 1);
    idle_check(2);

    // Two stop bits: 8 high cycles, then one idle cycle before the next start
    data[3] = 8'hFF;
    in_valid[3] = 1'b1;
    @(negedge clk);
    data[3] = 8'h00;
    @(negedge clk);
    in_valid[3] = 1'b0;
    check_frame(3, 8'hFF, 1'b0, 1'b0, 2);
    idle_check(3);
    check_frame(3, 8'h00, 1'b0, 1'b0, 2);
    idle_check(3);

    // FIFO full: bytes 1..5 taken on edges 0..4, byte 6 only on edge 43
    data[0] = 8'h01;
    in_valid[0] = 1'b1;
    fork
      begin
        int acc_cyc [6];
        int i;
        int cyc;
        logic acc;
        i = 0;
        cyc = 0;
        while (i < 6 && cyc < 100) begin
          acc = in_ready[0];
          @(negedge clk);
          if (acc) begin
            acc_cyc[i] = cyc;
            i++;
            if (i < 6) data[0] = 8'(i + 1);
            else in_valid[0] = 1'b0;
          end
          if (cyc == 4) begin
            check_value("full_count", 32'(fifo_count[0]), 32'd4);
            check_value("full_ready", 32'(in_ready[0]), 32'd0);
          end
          cyc++;
        end
        in_valid[0] = 1'b0;
        check_value("full_accepts", 32'(i), 32'd6);
        check_value("full_acc1", 32'(acc_cyc[0]), 32'd0);
        check_value("full_acc5", 32'(acc_cyc[4]), 32'd4);
        check_value("full_acc6", 32'(acc_cyc[5]), 32'd43);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int f = 1; f <= 6; f++) begin
          check_frame(0, 8'(f), 1'b0, 1'b0, 1);
          idle_check(0);
        end
        check_value("full_drained", 32'(fifo_count[0]), 32'd0);
      end
    join

    // Reset during data bit 3 of 0x55 with two bytes still queued
    data[0] = 8'h55;
    in_valid[0] = 1'b1;
    @(negedge clk);
    data[0] = 8'hAA;
    @(negedge clk);
    data[0] = 8'h33;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (15) @(negedge clk);
    check_value("pre_rst_bit3", 32'(txd[0]), 32'd0);
    check_value("pre_rst_count", 32'(fifo_count[0]), 32'd2);
    rst = 1'b1;
    data[0] = 8'hEE;
    in_valid[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    check_value("midrst_txd", 32'(txd[0]), 32'd1);
    check_value("midrst_count", 32'(fifo_count[0]), 32'd0);
    check_value("midrst_busy", 32'(busy[0]), 32'd0);
    check_value("midrst_ready", 32'(in_ready[0]), 32'd1);
    begin
      int bad;
      bad = 0;
      repeat (60) begin
        @(negedge clk);
        if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_count[0] !== 3'd0) bad++;
      end
      check_value("post_rst_quiet", 32'(bad), 32'd0);
    end
    data[0] = 8'h3C;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    check_frame(0, 8'h3C, 1'b0, 1'b0, 1);
    idle_check(0);

    // Loopback through a mid-bit sampling receiver
    fork
      begin
        for (int p = 0; p < 4; p++) begin
          data[0] = lb_bytes[p];
          in_valid[0] = 1'b1;
          @(negedge clk);
        end
        in_valid[0] = 1'b0;
      end
      begin
        for (int r = 0; r < 4; r++) begin
          logic [7:0] rx;
          int w;
          w = 0;
          while (txd[0] !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
          end
          check_value($sformatf("rx%0d_start_seen", r), 32'(w < 200), 32'd1);
          @(negedge clk);
          for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clk);
            rx[b] = txd[0];
          end
          repeat (CPB) @(negedge clk);
          check_value($sformatf("rx%0d_stop", r), 32'(txd[0]), 32'd1);
          check_value($sformatf("rx%0d_byte", r), 32'(rx), 32'(lb_bytes[r]));
        end
      end
    join

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
